// File: rtl/serial_addsub_pkg.sv
// serial_addsub_pkg: state encoding and default width for the bit-serial adder/subtractor
package serial_addsub_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  localparam int DATA_WIDTH_DEF = 8;
endpackage

// File: rtl/serial_addsub_bit_slice.sv
// serial_bit_slice: 1-bit look-ahead add/sub slice; in a b inv c, out sum c_next p g
module serial_bit_slice (
  input  logic a,
  input  logic b,
  input  logic inv,
  input  logic c,
  output logic sum,
  output logic c_next,
  output logic p,
  output logic g
);
  logic rb;
  always_comb begin
    rb = b ^ inv;
    sum = a ^ rb ^ c;
    g = a & rb;
    p = a | rb;
    c_next = g | (p & c);
  end
endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial add/sub; in clk rst_n start lhs rhs inv, out busy done res cout of
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] lhs,
  input  logic [DATA_WIDTH-1:0] rhs,
  input  logic                  inv,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] res,
  output logic                  cout,
  output logic                  of
);
  localparam int IW = $clog2(DATA_WIDTH);
  state_t state, state_nx;
  logic [IW-1:0] idx;
  logic [DATA_WIDTH-1:0] a_q, b_q, sh;
  logic inv_q, c, sum, c_nx, p, g, last;
  serial_bit_slice u_slice (
    .a(a_q[idx]), .b(b_q[idx]), .inv(inv_q), .c(c),
    .sum(sum), .c_next(c_nx), .p(p), .g(g)
  );
  always_comb assert (c_nx == (g | (p & c)));
  assign last = idx == IW'(DATA_WIDTH - 1);
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  always_comb busy = state == RUN;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      c <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      inv_q <= 1'b0;
      sh <= '0;
      res <= '0;
      cout <= 1'b0;
      of <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= state == RUN && last;
      if (state == IDLE && start) begin
        a_q <= lhs;
        b_q <= rhs;
        inv_q <= inv;
        c <= inv;
        idx <= '0;
      end else if (state == RUN) begin
        sh <= {sum, sh[DATA_WIDTH-1:1]};
        c <= c_nx;
        idx <= last ? '0 : idx + IW'(1);
        if (last) begin
          res <= {sum, sh[DATA_WIDTH-1:1]};
          cout <= c_nx;
          of <= c ^ c_nx;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_addsub.sv
// tb_serial_addsub: randomized and directed self-checking bench for serial_addsub
module tb_serial_addsub;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, inv = 1'b0;
  logic [7:0] lhs = '0, rhs = '0;
  logic busy, done, cout, of;
  logic [7:0] res;
  int errors = 0, checks = 0;

  serial_addsub #(.DATA_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .lhs(lhs), .rhs(rhs), .inv(inv),
    .busy(busy), .done(done), .res(res), .cout(cout), .of(of)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [7:0] a, input logic [7:0] b, input logic i,
                                output logic [7:0] r, output logic co, output logic ov);
    int ua, ub, sa, sb, s;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = i ? 8'(ua - ub) : 8'(ua + ub);
    co = i ? (ua >= ub) : (ua + ub > 255);
    s = i ? sa - sb : sa + sb;
    ov = (s > 127) || (s < -128);
  endfunction

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic i,
                        output logic [7:0] r, output logic co, output logic ov,
                        output int lat, output int bcnt);
    @(negedge clk);
    lhs = a; rhs = b; inv = i; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; bcnt = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (busy) bcnt++;
      if (done) break;
    end
    r = res; co = cout; ov = of;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({busy, done, res, cout, of} !== 12'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b res=%h cout=%b of=%b, want all 0", busy, done, res, cout, of);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [7:0] va [6] = '{8'h05, 8'h7F, 8'hFF, 8'h00, 8'h80, 8'h12};
    logic [7:0] vb [6] = '{8'h03, 8'h01, 8'h01, 8'h01, 8'h01, 8'h80};
    logic       vi [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] a, b, r, er;
    logic i, co, ov, eco, eov;
    int lat, bcnt;
    for (int n = 0; n < 30; n++) begin
      if (n < 6) begin a = va[n]; b = vb[n]; i = vi[n]; end
      else begin a = 8'($urandom); b = 8'($urandom); i = 1'($urandom); end
      model(a, b, i, er, eco, eov);
      run_op(a, b, i, r, co, ov, lat, bcnt);
      checks++;
      if (lat != 9 || bcnt != 8) begin
        errors++;
        $display("FAIL latency %h %s %h: done after %0d cycles busy %0d, want 9 and 8", a, i ? "-" : "+", b, lat, bcnt);
      end
      checks++;
      if ({r, co, ov} !== {er, eco, eov}) begin
        errors++;
        $display("FAIL arith %h %s %h: res=%h cout=%b of=%b, want res=%h cout=%b of=%b", a, i ? "-" : "+", b, r, co, ov, er, eco, eov);
      end
    end
  endtask

  task automatic test_isolation();
    logic [7:0] prev;
    int ndone;
    prev = res;
    @(negedge clk);
    lhs = 8'h10; rhs = 8'h20; inv = 1'b0; start = 1'b1;
    @(posedge clk);
    ndone = 0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        start = 1'b0;
        checks++;
        if (res !== 8'h30 || cout !== 1'b0 || of !== 1'b0) begin
          errors++;
          $display("FAIL isolation result: res=%h cout=%b of=%b, want 30 0 0", res, cout, of);
        end
      end else if (busy) begin
        checks++;
        if (res !== prev) begin
          errors++;
          $display("FAIL isolation hold: res=%h during run, want %h", res, prev);
        end
        lhs = 8'($urandom); rhs = 8'($urandom); inv = 1'($urandom); start = 1'b1;
      end else start = 1'b0;
    end
    checks++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL isolation dones: %0d, want 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    int last_d, nd, gaps_bad;
    logic pd;
    @(negedge clk);
    lhs = 8'h01; rhs = 8'h01; inv = 1'b0; start = 1'b1;
    last_d = -1; nd = 0; gaps_bad = 0; pd = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (pd) gaps_bad++;
        if (last_d >= 0 && n - last_d != 9) gaps_bad++;
        last_d = n;
        checks++;
        if (res !== 8'h02) begin
          errors++;
          $display("FAIL b2b result: res=%h, want 02", res);
        end
      end
      pd = done;
    end
    start = 1'b0;
    checks++;
    if (nd < 4 || gaps_bad != 0) begin
      errors++;
      $display("FAIL b2b spacing: %0d dones %0d bad gaps, want >=4 and 0", nd, gaps_bad);
    end
    repeat (12) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    logic [7:0] r;
    logic co, ov;
    int lat, bcnt, nd;
    @(negedge clk);
    lhs = 8'h7F; rhs = 8'h7F; inv = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, done, res, cout, of} !== 12'h0) begin
      errors++;
      $display("FAIL midop reset: busy=%b done=%b res=%h cout=%b of=%b, want all 0", busy, done, res, cout, of);
    end
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL midop aftermath: %0d cycles busy/done, want 0", nd);
    end
    run_op(8'h02, 8'h03, 1'b0, r, co, ov, lat, bcnt);
    checks++;
    if (r !== 8'h05 || lat != 9) begin
      errors++;
      $display("FAIL midop fresh: res=%h lat=%0d, want 05 and 9", r, lat);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_isolation();
    test_back_to_back();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
Bit-serial adder/subtractor that drives one 1-bit carry look-ahead slice per cycle. It latches a DATA_WIDTH-bit operand pair, feeds one bit pair per clock LSB-first with a registered carry, and assembles the result word with carry-out and signed overflow. Sits directly downstream of the operand source and around the 1-bit slice. It trades latency for area against a full-width parallel adder.

Parameters:
DATA_WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only when busy=0
lhs  input  DATA_WIDTH  left operand, captured on accepted start
rhs  input  DATA_WIDTH  right operand, captured on accepted start
inv  input  1  0 = lhs+rhs, 1 = lhs-rhs; captured on accepted start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when res/cout/of become valid
res  output  DATA_WIDTH  result word, held until the next done
cout  output  1  carry out of MSB; for subtract, 1 = no borrow
of  output  1  signed overflow = carry into MSB xor carry out of MSB

Behaviour:
- Reset: rst_n=0 at a rising edge forces state=IDLE, bit index=0, carry register=0, operand and shift registers=0, busy=0, done=0, res=0, cout=0, of=0. Reset applies in any state, including mid-operation. An in-flight operation is discarded and produces no done.
- States: IDLE, RUN.
- IDLE: busy=0. When start=1:
  - capture lhs, rhs and inv;
  - set carry register=inv;
  - set index=0;
  - go to RUN.
  start=0 stays in IDLE.
- RUN: busy=1. Each cycle processes bit k=index:
  - rb = rhs[k] xor inv
  - sum = lhs[k] xor rb xor c
  - g = lhs[k] and rb
  - p = lhs[k] or rb
  - c_next = g or (p and c)
  sum shifts into the result shift register MSB-ward, so after DATA_WIDTH shifts bit k is in position k. The carry register takes c_next and index increments.
- Final bit, k=DATA_WIDTH-1, in the same cycle:
  - res <= completed word;
  - cout <= c_next;
  - of <= c xor c_next;
  - done <= 1 for the following cycle;
  - state -> IDLE.
- Latency: accepted start at edge N means done=1 and valid outputs during the cycle after edge N+DATA_WIDTH. Exactly DATA_WIDTH RUN cycles.
- Back-to-back: a start presented while done=1 is accepted, because state is IDLE. Throughput is one operation per DATA_WIDTH+1 cycles.
- Operand stability:
  - start while busy=1 is ignored, not queued;
  - lhs/rhs/inv changes during RUN have no effect;
  - res/cout/of keep the previous result throughout RUN and change only at completion.
- Width rules:
  - index counter is $clog2(DATA_WIDTH) bits, no wrap beyond DATA_WIDTH-1;
  - arithmetic is modulo 2^DATA_WIDTH;
  - inv=1 computes lhs + ~rhs + 1.
- done is never high in two consecutive cycles for a single operation.
- No X on any output after reset.

Decomposition:
- Shared package: state encoding (IDLE=1'b0, RUN=1'b1) and the DATA_WIDTH default constant.
- One sub-module is natural: serial_bit_slice, combinational. Inputs a, b, inv, c. Outputs sum, c_next, p, g. It has the same gate structure as the existing 1-bit look-ahead slice.
- FSM, index counter, carry register, operand registers and result shift register live in serial_addsub.

Test Plan:
All scenarios use DATA_WIDTH=8.
- Add: lhs=0x05, rhs=0x03, inv=0, start pulse -> done exactly 9 cycles later, res=0x08, cout=0, of=0; busy high for 8 cycles.
- Signed overflow: 0x7F+0x01 -> res=0x80, cout=0, of=1. Unsigned carry: 0xFF+0x01 -> res=0x00, cout=1, of=0.
- Subtract: 0x00-0x01 (inv=1) -> res=0xFF, cout=0 (borrow), of=0. Then 0x80-0x01 -> res=0x7F, cout=1, of=1.
- Operand isolation: start with 0x10+0x20, change lhs/rhs/inv and pulse start every cycle while busy -> single done, res=0x30. res still shows the prior result until that done.
- Back-to-back: hold start=1 continuously with 0x01+0x01 -> done pulses every 9 cycles, res=0x02 each time, done never high two cycles running.
- Reset mid-op: start 0x7F+0x7F, drive rst_n=0 for one edge at RUN cycle 4 -> next cycle busy=0, done=0, res=0x00, cout=0, of=0. No done follows. A fresh 0x02+0x03 afterwards yields res=0x05.
